// File: rtl/rtoc_core_v2.sv
// Timestamped real-time output core: FWFT FIFO of {ts, data} words,
// each released on the cycle the global counter reaches its timestamp.
// Ports: clk, reset (async, high), flush, auto_start, write, fifo_din,
//   counter, error_clear -> counter_matched, late, rto_out, sticky
//   timestamp/overflow errors with captured words, full, empty, fill_level.
module rtoc_core_v2 #(
  parameter int DATA_WIDTH     = 1,
  parameter int DEPTH_LOG2     = 10,
  parameter int FULL_THRESHOLD = 1000,
  parameter int LATE_MODE      = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                auto_start,
  input  logic                write,
  input  logic [127:0]        fifo_din,
  input  logic [63:0]         counter,
  input  logic                error_clear,
  output logic                counter_matched,
  output logic                late,
  output logic [127:0]        rto_out,
  output logic                timestamp_error,
  output logic [127:0]        timestamp_error_data,
  output logic                overflow_error,
  output logic [127:0]        overflow_error_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] fill_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int WW    = 64 + DATA_WIDTH;
  localparam int ZW    = 64 - DATA_WIDTH;
  localparam logic [PW-1:0] THR = PW'(FULL_THRESHOLD);
  localparam bit LM = (LATE_MODE != 0);

  logic [WW-1:0]         r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         w_level;
  logic [WW-1:0]         w_head;
  logic [63:0]           w_head_ts;
  logic [127:0]          w_head_word;
  logic [127:0]          w_din_word;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_eval;
  logic                  w_on_time;
  logic                  w_is_late;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_unused;

  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign fill_level = w_level;
  assign full       = (w_level >= THR);
  assign empty      = (w_level == '0);

  // Head is read combinationally so it is visible as soon as empty drops.
  assign w_head      = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign w_head_ts   = w_head[WW-1:DATA_WIDTH];
  assign w_head_word = {w_head_ts, {ZW{1'b0}},
                        w_head[DATA_WIDTH-1:0]};
  assign w_din_word  = {fifo_din[127:64], {ZW{1'b0}},
                        fifo_din[DATA_WIDTH-1:0]};
  assign w_unused    = ^fifo_din[63:DATA_WIDTH];

  // full is sampled on the pre-edge level: a pop this cycle does not
  // make room for a simultaneous write.
  assign w_push    = write && !full && !flush;
  assign w_drop    = write && full && !flush;
  assign w_eval    = auto_start && !empty;
  assign w_on_time = w_eval && (w_head_ts == counter);
  assign w_is_late = w_eval && (w_head_ts < counter);
  assign w_pop     = w_on_time || w_is_late;
  assign w_issue   = w_on_time || (w_is_late && LM);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <=
        {fifo_din[127:64], fifo_din[DATA_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr             <= '0;
      r_rd_ptr             <= '0;
      counter_matched      <= 1'b0;
      late                 <= 1'b0;
      rto_out              <= '0;
      timestamp_error      <= 1'b0;
      timestamp_error_data <= '0;
      overflow_error       <= 1'b0;
      overflow_error_data  <= '0;
    end else if (flush) begin
      r_wr_ptr             <= '0;
      r_rd_ptr             <= '0;
      counter_matched      <= 1'b0;
      late                 <= 1'b0;
      rto_out              <= '0;
      timestamp_error      <= 1'b0;
      timestamp_error_data <= '0;
      overflow_error       <= 1'b0;
      overflow_error_data  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      counter_matched <= w_issue;
      late            <= w_is_late && LM;
      if (w_issue) rto_out <= w_head_word;

      // A new error in the same cycle as error_clear wins.
      if (w_is_late) begin
        timestamp_error <= 1'b1;
        if (!timestamp_error || error_clear)
          timestamp_error_data <= w_head_word;
      end else if (error_clear) begin
        timestamp_error      <= 1'b0;
        timestamp_error_data <= '0;
      end

      if (w_drop) begin
        overflow_error <= 1'b1;
        if (!overflow_error || error_clear)
          overflow_error_data <= w_din_word;
      end else if (error_clear) begin
        overflow_error      <= 1'b0;
        overflow_error_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rtoc_core_v2.sv
// Scoreboard bench for rtoc_core_v2: drop-mode and issue-late instances
// share stimulus; per-instance monitors check every issued word.
`timescale 1ns/1ps
module tb_rtoc_core_v2;
  localparam int DW = 8;
  localparam int DL = 4;
  localparam int FT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic auto_start = 1'b0;
  logic write = 1'b0;
  logic error_clear = 1'b0;
  logic [127:0] fifo_din = '0;
  logic [63:0] counter = '0;

  logic cm0, lt0, te0, oe0, fu0, em0;
  logic cm1, lt1, te1, oe1, fu1, em1;
  logic [127:0] ro0, ted0, oed0, ro1, ted1, oed1;
  logic [DL:0] fl0, fl1;

  always #5 clk = ~clk;

  rtoc_core_v2 #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL),
    .FULL_THRESHOLD(FT), .LATE_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .auto_start(auto_start), .write(write),
    .fifo_din(fifo_din), .counter(counter),
    .error_clear(error_clear), .counter_matched(cm0),
    .late(lt0), .rto_out(ro0), .timestamp_error(te0),
    .timestamp_error_data(ted0), .overflow_error(oe0),
    .overflow_error_data(oed0), .full(fu0), .empty(em0),
    .fill_level(fl0));

  rtoc_core_v2 #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL),
    .FULL_THRESHOLD(FT), .LATE_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .auto_start(auto_start), .write(write),
    .fifo_din(fifo_din), .counter(counter),
    .error_clear(error_clear), .counter_matched(cm1),
    .late(lt1), .rto_out(ro1), .timestamp_error(te1),
    .timestamp_error_data(ted1), .overflow_error(oe1),
    .overflow_error_data(oed1), .full(fu1), .empty(em1),
    .fill_level(fl1));

  typedef struct {
    logic [127:0] w;
    bit           lt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int checks = 0;
  int failures = 0;
  logic [63:0] prev_cnt = '0;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pk(logic [63:0] ts,
                                      logic [7:0] d);
    return {ts, 56'h0, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Garbage in fifo_din[63:8] must never reach any output.
  task automatic push(logic [63:0] ts, logic [7:0] d,
                      bit i0, bit i1, bit l);
    exp_t e;
    write = 1'b1;
    fifo_din = {ts, 56'hA5A55A5AC3C33C, d};
    e.w = pk(ts, d);
    e.lt = l;
    if (i0) q0.push_back(e);
    if (i1) q1.push_back(e);
    tick();
    write = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (cm0) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut0_unexpected_issue actual=%h required=none",
                   ro0);
        end else begin
          e0 = q0.pop_front();
          chk("dut0_rto_out", ro0, e0.w);
          chk("dut0_late", 128'(lt0), 128'(e0.lt));
          if (!e0.lt)
            chk("dut0_issue_time", 128'(prev_cnt),
                128'(e0.w[127:64]));
        end
      end else if (lt0) begin
        checks++;
        failures++;
        $display("FAIL dut0_late_without_match actual=1 required=0");
      end
      if (cm1) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut1_unexpected_issue actual=%h required=none",
                   ro1);
        end else begin
          e1 = q1.pop_front();
          chk("dut1_rto_out", ro1, e1.w);
          chk("dut1_late", 128'(lt1), 128'(e1.lt));
          if (!e1.lt)
            chk("dut1_issue_time", 128'(prev_cnt),
                128'(e1.w[127:64]));
        end
      end else if (lt1) begin
        checks++;
        failures++;
        $display("FAIL dut1_late_without_match actual=1 required=0");
      end
    end
    prev_cnt = counter;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_empty0", 128'(em0), 128'(1));
    chk("rst_empty1", 128'(em1), 128'(1));
    chk("rst_fill0", 128'(fl0), 128'(0));
    chk("rst_full0", 128'(fu0), 128'(0));
    chk("rst_rto0", ro0, 128'(0));
    chk("rst_match0", 128'(cm0), 128'(0));
    chk("rst_terr1", 128'(te1), 128'(0));
    #2 reset = 1'b0;
    tick();

    // In-order dispatch, including back-to-back ts 100/101.
    counter = 64'd90;
    auto_start = 1'b1;
    push(64'd100, 8'h01, 1'b1, 1'b1, 1'b0);
    push(64'd101, 8'h00, 1'b1, 1'b1, 1'b0);
    push(64'd105, 8'h01, 1'b1, 1'b1, 1'b0);
    for (int c = 91; c <= 110; c++) begin
      counter = 64'(c);
      tick();
    end
    tick();
    @(negedge clk);
    chk("t1_empty0", 128'(em0), 128'(1));
    chk("t1_empty1", 128'(em1), 128'(1));
    chk("t1_rto_hold0", ro0, pk(64'd105, 8'h01));
    chk("t1_terr0", 128'(te0), 128'(0));
    chk("t1_q0", 128'(q0.size()), 128'(0));

    // Late words: drop in dut0, issue-late in dut1.
    counter = 64'd60;
    push(64'd50, 8'hAA, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("t2_terr0", 128'(te0), 128'(1));
    chk("t2_tdata0_ts", 128'(ted0[127:64]), 128'(50));
    chk("t2_empty0", 128'(em0), 128'(1));
    chk("t2_terr1", 128'(te1), 128'(1));
    chk("t2_tdata1", ted1, pk(64'd50, 8'hAA));
    chk("t2_rto1_ts", 128'(ro1[127:64]), 128'(50));
    push(64'd55, 8'h55, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("t2_keep0", ted0, pk(64'd50, 8'hAA));
    chk("t2_keep1", ted1, pk(64'd50, 8'hAA));
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    @(negedge clk);
    chk("t2_clr_flag0", 128'(te0), 128'(0));
    chk("t2_clr_data0", ted0, 128'(0));
    chk("t2_clr_flag1", 128'(te1), 128'(0));
    chk("t2_clr_data1", ted1, 128'(0));
    // Clear in the same cycle as a new late error: error wins.
    push(64'd57, 8'h57, 1'b0, 1'b1, 1'b1);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    @(negedge clk);
    chk("t2_win_flag0", 128'(te0), 128'(1));
    chk("t2_win_data0", ted0, pk(64'd57, 8'h57));
    chk("t2_win_data1", ted1, pk(64'd57, 8'h57));

    // Threshold and overflow with dispatch held.
    auto_start = 1'b0;
    counter = 64'd0;
    for (int i = 0; i < 6; i++)
      push(64'(1000 + i), 8'(i), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_fill0", 128'(fl0), 128'(4));
    chk("t3_full0", 128'(fu0), 128'(1));
    chk("t3_oerr0", 128'(oe0), 128'(1));
    chk("t3_odata0", oed0, pk(64'd1004, 8'h04));
    chk("t3_fill1", 128'(fl1), 128'(4));
    chk("t3_odata1_ts", 128'(oed1[127:64]), 128'(1004));
    chk("t3_empty0", 128'(em0), 128'(0));

    // Flush, refill three, then flush together with a write.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_fill_a", 128'(fl0), 128'(0));
    chk("t4_oerr_a", 128'(oe0), 128'(0));
    for (int i = 0; i < 3; i++)
      push(64'(2000 + i), 8'(i), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_fill3", 128'(fl0), 128'(3));
    chk("t4_full3", 128'(fu0), 128'(0));
    flush = 1'b1;
    write = 1'b1;
    fifo_din = {64'd3000, 64'h77};
    tick();
    flush = 1'b0;
    write = 1'b0;
    @(negedge clk);
    chk("t4_fill0", 128'(fl0), 128'(0));
    chk("t4_empty0", 128'(em0), 128'(1));
    chk("t4_empty1", 128'(em1), 128'(1));
    chk("t4_rto0", ro0, 128'(0));
    chk("t4_rto1", ro1, 128'(0));
    chk("t4_terr0", 128'(te0), 128'(0));
    chk("t4_tdata1", ted1, 128'(0));
    chk("t4_odata0", oed0, 128'(0));

    // Async reset between edges.
    counter = 64'd200;
    auto_start = 1'b1;
    push(64'd200, 8'h33, 1'b1, 1'b1, 1'b0);
    push(64'd150, 8'h44, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("t5_pre_rto0", ro0, pk(64'd200, 8'h33));
    chk("t5_pre_rto1", ro1, pk(64'd150, 8'h44));
    chk("t5_pre_terr0", 128'(te0), 128'(1));
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_rto0", ro0, 128'(0));
    chk("t5_rto1", ro1, 128'(0));
    chk("t5_terr0", 128'(te0), 128'(0));
    chk("t5_tdata1", ted1, 128'(0));
    chk("t5_empty0", 128'(em0), 128'(1));
    #4 reset = 1'b0;
    tick();
    @(negedge clk);
    chk("end_q0", 128'(q0.size()), 128'(0));
    chk("end_q1", 128'(q1.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
